hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It sits beside the ID stage and consumes the decoder's per-instruction hazard class (`hazard_optype`), operand-use flags and register indices. It tracks the classes of the instructions in EX and MEM in internal state, and from that generates stage enables, bubble/flush controls and operand-forwarding selects. Branches and jumps resolve in ID, so forwarding targets the ID-stage operands; store data gets a late EX-stage path.

## Interface
Parameters:
- `REG_W`, 5, register index width

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `rs1_ID`, `rs2_ID`  in  REG_W  source indices of instruction in ID
- `rs1use_ID`, `rs2use_ID`  in  1  source actually read (decoder `rs1use`/`rs2use`)
- `rd_ID`  in  REG_W  destination index of instruction in ID
- `hazard_optype_ID`  in  2  0 none, 1 ALU-writer, 2 load, 3 store
- `Branch_ID`  in  1  taken branch/JAL/JALR resolved in ID
- `PC_EN_IF`  out  1  PC register enable
- `reg_FD_EN`  out  1  IF/ID register enable
- `reg_FD_flush`  out  1  IF/ID register clear (insert bubble)
- `reg_DE_flush`  out  1  ID/EX register clear (insert bubble)
- `forward_ctrl_A`, `forward_ctrl_B`  out  2  ID operand source: 0 regfile, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data
- `forward_ctrl_ls`  out  1  EX store-data source: 0 EX rs2 value, 1 MEM load data
- `stall_cnt`, `flush_cnt`  out  32  performance counters (see Configuration)

## Operation
- State: `optype_EX`, `rd_EX`, `rs2_EX`, `optype_MEM`, `rd_MEM`. On each clock, EX←ID (or bubble) and MEM←EX.
- A bubble sets `optype_EX`=0 and `rd_EX`=0. A bubble is inserted when `stall` or `reg_DE_flush` is asserted.
- Match rule: `hit(rs, use, rd, t)` = `use` & `rs`≠0 & `rs`==`rd` & `t`∈{1,2}.
- `stall` is asserted when `optype_EX`==2 and either of these holds:
  - `hit(rs1_ID)`;
  - `hit(rs2_ID)` with `hazard_optype_ID`≠3.
- Store-after-load on rs2 does not stall. It is served by `forward_ctrl_ls` one cycle later.
- `forward_ctrl_A` is computed as follows; `forward_ctrl_B` is identical using `rs2`:
  - 1 if hit on EX with `optype_EX`==1;
  - else 2 if hit on MEM with `optype_MEM`==1;
  - else 3 if hit on MEM with `optype_MEM`==2;
  - else 0.
- EX always has priority over MEM.
- `forward_ctrl_ls` = (`optype_EX`==3) & (`optype_MEM`==2) & `rs2_EX`≠0 & `rs2_EX`==`rd_MEM`.
- WB→ID hazards are not handled here. The register file writes before it reads within the same cycle.
- Control outputs:
  - `stall`: `PC_EN_IF`=0, `reg_FD_EN`=0, `reg_DE_flush`=1, `reg_FD_flush`=0.
  - `Branch_ID` & !`stall`: `reg_FD_flush`=1. PC and IF/ID stay enabled.
  - `stall` takes priority over `Branch_ID`. A branch whose operands are stalled is ignored until its operands are valid.
- All outputs are combinational from state and ID inputs. There is no internal FSM beyond the stage shadow registers.

## Timing
- Reset: all state registers 0. With `rst` high:
  - `PC_EN_IF`=1, `reg_FD_EN`=1;
  - all flush outputs 0, all forward selects 0;
  - counters 0.
- A reset applied mid-stream discards all tracked hazards on the next edge.
- Load-use latency: load in ID at cycle t; dependent instruction in ID at t+1.
  - Cycle t+1: `stall`=1.
  - Cycle t+2: load is in MEM, `forward_ctrl`=3, pipeline proceeds.
  - Exactly one bubble.
- ALU→dependent: zero stall. Back-to-back gives select 1; with one instruction between, select 2.
- Simultaneous EX and MEM hits on the same register: EX wins.
- rd=0 never matches, even when the writer class is nonzero.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every cycle with `stall`=1.
  - `flush_cnt` increments on every cycle with `reg_FD_flush`=1.
  - Both are 32-bit, wrap 0xFFFFFFFF→0, and are cleared by `rst`.
- Not defined: both ports are tied to 0 and no counter flops are synthesized.

## Test plan
- `lw x5,0(x1)` then `add x6,x5,x2`: exactly one cycle with `PC_EN_IF`=0 / `reg_DE_flush`=1, then `forward_ctrl_A`=3, `stall_cnt`=1.
- `addi x3,x0,7`; `sub x4,x3,x3`; `or x7,x3,x4`:
  - sub sees A=B=1;
  - or sees A=2, B=1;
  - no stall.
- `lw x8,4(x2)` then `sw x8,0(x9)`: no stall; next cycle `forward_ctrl_ls`=1, `forward_ctrl_B`=0.
- `lw x0,0(x1)` then `add x2,x0,x0`: no stall, all selects 0.
- Taken `beq` with no dependency: `reg_FD_flush`=1 for one cycle, `flush_cnt`=1. Taken `beq x5,...` directly after `lw x5`: one stall cycle with `reg_FD_flush`=0, then flush with A=3.
- Assert `rst` while a load sits in EX: next cycle no stall, selects 0, counters 0 (with macro defined).

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I ID-stage hazard controller: load-use stall, branch flush, operand forwarding
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_ID,
    input  logic [REG_W-1:0] rs2_ID,
    input  logic             rs1use_ID,
    input  logic             rs2use_ID,
    input  logic [REG_W-1:0] rd_ID,
    input  logic [1:0]       hazard_optype_ID,
    input  logic             Branch_ID,
    output logic             PC_EN_IF,
    output logic             reg_FD_EN,
    output logic             reg_FD_flush,
    output logic             reg_DE_flush,
    output logic [1:0]       forward_ctrl_A,
    output logic [1:0]       forward_ctrl_B,
    output logic             forward_ctrl_ls,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_ALU   = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

    logic [1:0]       optype_EX;
    logic [1:0]       optype_MEM;
    logic [REG_W-1:0] rd_EX;
    logic [REG_W-1:0] rs2_EX;
    logic [REG_W-1:0] rd_MEM;
    logic             stall;

    function automatic logic hit(input logic [REG_W-1:0] rs, input logic used,
                                 input logic [REG_W-1:0] rd, input logic [1:0] t);
        return used && (rs != '0) && (rs == rd) && ((t == OP_ALU) || (t == OP_LOAD));
    endfunction

    // EX has priority over MEM so the youngest producer wins.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs, input logic used,
                                           input logic [1:0] opt_ex, input logic [REG_W-1:0] rd_ex,
                                           input logic [1:0] opt_mem, input logic [REG_W-1:0] rd_mem);
        if (hit(rs, used, rd_ex, opt_ex) && (opt_ex == OP_ALU)) begin
            return 2'd1;
        end else if (hit(rs, used, rd_mem, opt_mem) && (opt_mem == OP_ALU)) begin
            return 2'd2;
        end else if (hit(rs, used, rd_mem, opt_mem) && (opt_mem == OP_LOAD)) begin
            return 2'd3;
        end
        return 2'd0;
    endfunction

    // Store data from a load in EX is picked up late in EX, so rs2 of a store never stalls.
    assign stall = !rst && (optype_EX == OP_LOAD) &&
                   (hit(rs1_ID, rs1use_ID, rd_EX, optype_EX) ||
                    (hit(rs2_ID, rs2use_ID, rd_EX, optype_EX) && (hazard_optype_ID != OP_STORE)));

    assign PC_EN_IF     = !stall;
    assign reg_FD_EN    = !stall;
    assign reg_DE_flush = stall;
    assign reg_FD_flush = !rst && Branch_ID && !stall;

    assign forward_ctrl_A  = rst ? 2'd0 :
                             fwd_sel(rs1_ID, rs1use_ID, optype_EX, rd_EX, optype_MEM, rd_MEM);
    assign forward_ctrl_B  = rst ? 2'd0 :
                             fwd_sel(rs2_ID, rs2use_ID, optype_EX, rd_EX, optype_MEM, rd_MEM);
    assign forward_ctrl_ls = !rst && (optype_EX == OP_STORE) && (optype_MEM == OP_LOAD) &&
                             (rs2_EX != '0) && (rs2_EX == rd_MEM);

    always_ff @(posedge clk) begin
        if (rst) begin
            optype_EX  <= OP_NONE;
            rd_EX      <= '0;
            rs2_EX     <= '0;
            optype_MEM <= OP_NONE;
            rd_MEM     <= '0;
        end else begin
            optype_MEM <= optype_EX;
            rd_MEM     <= rd_EX;
            if (stall || reg_DE_flush) begin
                optype_EX <= OP_NONE;
                rd_EX     <= '0;
                rs2_EX    <= '0;
            end else begin
                optype_EX <= hazard_optype_ID;
                rd_EX     <= rd_ID;
                rs2_EX    <= rs2_ID;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall) begin
                stall_q <= stall_q + 32'd1;
            end
            if (reg_FD_flush) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    typedef struct packed {
        logic       pc_en;
        logic       fd_en;
        logic       fd_fl;
        logic       de_fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       ls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID;
    logic        rs1use_ID, rs2use_ID;
    logic [1:0]  hazard_optype_ID;
    logic        Branch_ID;
    logic        PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
    logic [1:0]  forward_ctrl_A, forward_ctrl_B;
    logic        forward_ctrl_ls;
    logic [31:0] stall_cnt, flush_cnt;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_stall = 0;
    logic [31:0] exp_flush = 0;

    hazard_ctrl #(.REG_W(5)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .rd_ID(rd_ID), .hazard_optype_ID(hazard_optype_ID), .Branch_ID(Branch_ID),
        .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
        .forward_ctrl_ls(forward_ctrl_ls),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One ID-stage cycle: drive, queue the expectation, compare mid-cycle, then advance.
    task automatic issue(input string tag,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic [1:0] opt, input logic br,
                         input logic pc, input logic fl,
                         input logic [1:0] fa, input logic [1:0] fb, input logic ls);
        exp_t e;
        rs1_ID = r1; rs1use_ID = u1; rs2_ID = r2; rs2use_ID = u2;
        rd_ID = rd; hazard_optype_ID = opt; Branch_ID = br;
        e = '{pc_en: pc, fd_en: pc, fd_fl: fl, de_fl: !pc, fa: fa, fb: fb, ls: ls};
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, ".pc_en"},    {31'd0, PC_EN_IF},        {31'd0, e.pc_en});
        check({tag, ".fd_en"},    {31'd0, reg_FD_EN},       {31'd0, e.fd_en});
        check({tag, ".fd_flush"}, {31'd0, reg_FD_flush},    {31'd0, e.fd_fl});
        check({tag, ".de_flush"}, {31'd0, reg_DE_flush},    {31'd0, e.de_fl});
        check({tag, ".fwd_a"},    {30'd0, forward_ctrl_A},  {30'd0, e.fa});
        check({tag, ".fwd_b"},    {30'd0, forward_ctrl_B},  {30'd0, e.fb});
        check({tag, ".fwd_ls"},   {31'd0, forward_ctrl_ls}, {31'd0, e.ls});
        check({tag, ".stall_cnt"}, stall_cnt, exp_stall);
        check({tag, ".flush_cnt"}, flush_cnt, exp_flush);
        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        if (rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            exp_stall = exp_stall + {31'd0, !e.pc_en};
            exp_flush = exp_flush + {31'd0, e.fd_fl};
        end
`endif
    endtask

    task automatic nop(input string tag);
        issue(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rs1_ID = '0; rs2_ID = '0; rd_ID = '0;
        rs1use_ID = 1'b0; rs2use_ID = 1'b0; hazard_optype_ID = '0; Branch_ID = 1'b0;
        @(posedge clk);
        #1;
        // rst held high with a load-use pattern on the inputs: controls stay idle
        issue("reset", 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        rst = 1'b0;
        nop("nop0");
        nop("nop1");

        // lw x5,0(x1); add x6,x5,x2 -> one stall, then load-data forward
        issue("lw_x5",    5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        issue("add_stall",5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        issue("add_fwd3", 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 2'd1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
        nop("nop2");
        nop("nop3");

        // addi x3,x0,7; sub x4,x3,x3; or x7,x3,x4
        issue("addi_x3",  5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        issue("sub_x4",   5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 2'd1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0);
        issue("or_x7",    5'd3, 1'b1, 5'd4, 1'b1, 5'd7, 2'd1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 1'b0);

        // Same register written in EX and MEM: EX wins
        issue("addi_x10a",5'd0, 1'b1, 5'd0, 1'b0, 5'd10, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        issue("addi_x10b",5'd0, 1'b1, 5'd0, 1'b0, 5'd10, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        issue("add_x11",  5'd10,1'b1, 5'd10,1'b1, 5'd11, 2'd1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0);
        nop("nop4");
        nop("nop5");

        // lw x8,4(x2); sw x8,0(x9) -> no stall, late store-data forward
        issue("lw_x8",    5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        issue("sw_x8",    5'd9, 1'b1, 5'd8, 1'b1, 5'd0, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        issue("sw_ls",    5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
        nop("nop6");

        // lw x0,0(x1); add x2,x0,x0 -> x0 never matches
        issue("lw_x0",    5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        issue("add_x0",   5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        nop("nop7");
        nop("nop8");

        // Taken beq with no dependency
        issue("beq_free", 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
        nop("nop9");
        nop("nop10");

        // lw x5; beq x5,x6 taken -> stall without flush, then flush with load forward
        issue("lw_x5b",   5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        issue("beq_stall",5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        issue("beq_go",   5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 1'b0);
        nop("nop11");
        nop("nop12");

        // Reset while a load sits in EX discards the hazard and clears the counters
        issue("lw_x5c",   5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        rst = 1'b1;
        rs1_ID = 5'd5; rs1use_ID = 1'b1; rs2_ID = 5'd2; rs2use_ID = 1'b1;
        rd_ID = 5'd6; hazard_optype_ID = 2'd1; Branch_ID = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        issue("post_rst", 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
